regfile_write_2w: RTL and testbench
===================================

Name: regfile_write_2w

Overview:
- Write side of the 2-wide register file: a two-port write decoder, the register array, and an issue/writeback pending scoreboard.
- Takes up to two writebacks per cycle, slot 0 older and slot 1 younger.
- Exposes every register word in parallel on a flat bus, which feeds the 32:1 read-select muxes of each read port.
- Tracks which registers have an in-flight producer so the issue logic can stall or bypass.

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 5, register address width; register count NREGS = 2^ADDR_W = 32.

Ports:
- clock  input  1  rising-edge clock.
- ctrl_reset  input  1  synchronous reset, active-low; sampled on the rising edge of clock.
- ctrl_we0  input  1  slot-0 (older) write enable.
- ctrl_wreg0  input  ADDR_W  slot-0 destination register.
- data_w0  input  WIDTH  slot-0 write data.
- ctrl_we1  input  1  slot-1 (younger) write enable.
- ctrl_wreg1  input  ADDR_W  slot-1 destination register.
- data_w1  input  WIDTH  slot-1 write data.
- ctrl_iss0  input  1  slot-0 instruction issued with a destination register.
- ctrl_ireg0  input  ADDR_W  slot-0 issued destination register.
- ctrl_iss1  input  1  slot-1 instruction issued with a destination register.
- ctrl_ireg1  input  ADDR_W  slot-1 issued destination register.
- regs_flat  output  NREGS*WIDTH  all registers; register i is at bits [WIDTH*i+WIDTH-1 : WIDTH*i].
- pending  output  NREGS  bit i = 1 while register i has an issued, unwritten producer.
- wr_conflict  output  1  one-cycle pulse: the previous cycle had both writes to the same nonzero register.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clock.
  - ctrl_reset=0 at an edge: all registers <= 0, pending <= 0, wr_conflict <= 0.
  - Reset overrides every write and issue input in that cycle, including mid-burst.
  - regs_flat, pending and wr_conflict are driven directly from flops; no combinational input-to-output path.
- Write latency:
  - A write sampled at edge N is visible on regs_flat after edge N.
  - There is no write-through to regs_flat within the same cycle; same-cycle forwarding belongs to the bypass network.
- Register 0:
  - Hardwired to zero; writes to address 0 are dropped.
  - pending[0] is never set.
  - Slice 0 of regs_flat is constant 0.
- Write decode:
  - Each port decodes its address one-hot, gated by its ctrl_we.
  - Register i loads data_w1 if port 1 hits i.
  - Otherwise register i loads data_w0 if port 0 hits i.
  - Otherwise register i holds its value.
- Write collision (ctrl_we0 = ctrl_we1 = 1, ctrl_wreg0 = ctrl_wreg1 ≠ 0):
  - Slot 1 wins (program order).
  - wr_conflict = 1 for exactly the next cycle.
  - In every other cycle wr_conflict = 0.
- Scoreboard update per register i (i ≠ 0), evaluated each cycle:
  - set_i = (ctrl_iss0 and ctrl_ireg0 = i) or (ctrl_iss1 and ctrl_ireg1 = i).
  - clr_i = (ctrl_we0 and ctrl_wreg0 = i) or (ctrl_we1 and ctrl_wreg1 = i).
  - Next pending[i] = set_i ? 1 : (clr_i ? 0 : pending[i]).
  - Set wins over clear: a new producer issued in the same cycle as the old one's writeback keeps the register pending.
- Scoreboard boundary cases:
  - Both issue slots naming the same register set the bit once; no counting.
  - A write to a register that is not pending is legal; the data is written and pending stays 0.
- Data handling:
  - Widths are fixed; there is no arithmetic and data is never truncated.
  - X or unknown addresses are not expected; the enable gates decoding.

Test Plan:
1. Reset: hold ctrl_reset=0 for 2 cycles with ctrl_we0=1, ctrl_wreg0=3, data_w0=0xDEADBEEF → regs_flat all 0, pending 0, wr_conflict 0.
2. Dual write: we0 reg5=0x11111111 and we1 reg9=0x22222222 in one cycle → next cycle reg5=0x11111111, reg9=0x22222222, all others unchanged, wr_conflict=0.
3. Collision: we0 reg7=0xAAAA0000 and we1 reg7=0x0000BBBB → reg7=0x0000BBBB; wr_conflict=1 for exactly one cycle, then 0.
4. Register 0: we0 reg0=0xFFFFFFFF and iss0 reg0 → regs_flat[31:0]=0 and pending[0]=0.
5. Scoreboard:
   - Cycle A: iss0 reg4 → pending[4]=1.
   - Cycle B: we1 reg4 together with iss1 reg4 → pending[4] stays 1.
   - Cycle C: we0 reg4 alone → pending[4]=0, and reg4 holds the cycle-C data.
6. Reset mid-operation: pending[4]=1, pending[12]=1 and reg12=0x5, then ctrl_reset=0 for one cycle with we1 reg12=0x9 → reg12=0 and pending all 0; with reset released, the next write proceeds normally.

Source files
------------

// File: rtl/regfile_write_2w_if.sv
// regfile_write_2w_if
//   Bundles the write-side traffic of the 2-wide register file: two
//   writeback ports, two issue (scoreboard-set) ports, and the register
//   file state returned to the read/issue logic.
//
//   Signals (directions seen from the register file, modport slave):
//     ctrl_we0/ctrl_wreg0/data_w0    in   slot-0 (older) writeback
//     ctrl_we1/ctrl_wreg1/data_w1    in   slot-1 (younger) writeback
//     ctrl_iss0/ctrl_ireg0           in   slot-0 issue with destination
//     ctrl_iss1/ctrl_ireg1           in   slot-1 issue with destination
//     regs_flat                      out  all registers, reg i at [WIDTH*i +: WIDTH]
//     pending                        out  bit i = register i awaits writeback
//     wr_conflict                    out  pulse: last cycle both ports wrote one reg
//
//   Handshake semantics: there is no valid/ready back-pressure. Each
//   ctrl_we*/ctrl_iss* bit acts as a valid qualifier that is consumed
//   unconditionally on the rising edge where it is high; the register
//   file is always ready.
interface regfile_write_2w_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  localparam int NREGS = 1 << ADDR_W;

  logic                   ctrl_we0;
  logic [ADDR_W-1:0]      ctrl_wreg0;
  logic [WIDTH-1:0]       data_w0;
  logic                   ctrl_we1;
  logic [ADDR_W-1:0]      ctrl_wreg1;
  logic [WIDTH-1:0]       data_w1;
  logic                   ctrl_iss0;
  logic [ADDR_W-1:0]      ctrl_ireg0;
  logic                   ctrl_iss1;
  logic [ADDR_W-1:0]      ctrl_ireg1;
  logic [NREGS*WIDTH-1:0] regs_flat;
  logic [NREGS-1:0]       pending;
  logic                   wr_conflict;

  // Pipeline / issue side: drives writebacks and issues, observes state.
  modport master (
    output ctrl_we0, ctrl_wreg0, data_w0,
    output ctrl_we1, ctrl_wreg1, data_w1,
    output ctrl_iss0, ctrl_ireg0, ctrl_iss1, ctrl_ireg1,
    input  regs_flat, pending, wr_conflict
  );

  // Register file side.
  modport slave (
    input  ctrl_we0, ctrl_wreg0, data_w0,
    input  ctrl_we1, ctrl_wreg1, data_w1,
    input  ctrl_iss0, ctrl_ireg0, ctrl_iss1, ctrl_ireg1,
    output regs_flat, pending, wr_conflict
  );
endinterface

// File: rtl/regfile_write_2w.sv
// regfile_write_2w
//   Write side of the 2-wide register file: one-hot write decoders for the
//   two writeback ports, the register array (register 0 hardwired to zero),
//   and the pending scoreboard used by issue to stall or bypass.
//
//   Ports:
//     clock       in   rising-edge clock
//     ctrl_reset  in   synchronous active-low reset
//     bus         slave modport of regfile_write_2w_if (writes, issues,
//                 regs_flat / pending / wr_conflict outputs)
//
//   All outputs come straight from flops; writes become visible the cycle
//   after they are sampled (no write-through).
module regfile_write_2w #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  regfile_write_2w_if.slave  bus
);

  localparam int NREGS = 1 << ADDR_W;

  // One-hot hit vectors per port; bit 0 is forced low so register 0 is
  // never written and never marked pending.
  logic [NREGS-1:0] hit0;
  logic [NREGS-1:0] hit1;
  logic [NREGS-1:0] set_v;

  always_comb begin
    hit0  = '0;
    hit1  = '0;
    set_v = '0;
    for (int i = 1; i < NREGS; i++) begin
      hit0[i]  = bus.ctrl_we0  && (bus.ctrl_wreg0 == ADDR_W'(i));
      hit1[i]  = bus.ctrl_we1  && (bus.ctrl_wreg1 == ADDR_W'(i));
      set_v[i] = (bus.ctrl_iss0 && (bus.ctrl_ireg0 == ADDR_W'(i))) ||
                 (bus.ctrl_iss1 && (bus.ctrl_ireg1 == ADDR_W'(i)));
    end
  end

  // Collision detect: both ports hit the same real register this cycle.
  logic wr_conflict_d;
  logic wr_conflict_q;

  always_comb begin
    wr_conflict_d = bus.ctrl_we0 && bus.ctrl_we1 &&
                    (bus.ctrl_wreg0 == bus.ctrl_wreg1) &&
                    (bus.ctrl_wreg0 != '0);
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Pending scoreboard for registers 1..NREGS-1. A same-cycle issue beats
  // the writeback of the previous producer, so the bit stays set.
  logic [NREGS-1:1] pending_d;
  logic [NREGS-1:1] pending_q;

  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NREGS; i++) begin
      if (set_v[i]) begin
        pending_d[i] = 1'b1;
      end else if (hit0[i] || hit1[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Register array. Slot 1 is younger, so it has priority on a collision.
  logic [NREGS*WIDTH-1:0] regs_flat_w;

  assign regs_flat_w[WIDTH-1:0] = '0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    logic [WIDTH-1:0] reg_d;
    logic [WIDTH-1:0] reg_q;

    always_comb begin
      reg_d = reg_q;
      if (hit1[gi]) begin
        reg_d = bus.data_w1;
      end else if (hit0[gi]) begin
        reg_d = bus.data_w0;
      end
    end

    always_ff @(posedge clock) begin
      if (!ctrl_reset) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign regs_flat_w[WIDTH*gi +: WIDTH] = reg_q;
  end

  assign bus.regs_flat   = regs_flat_w;
  assign bus.pending     = {pending_q, 1'b0};
  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_write_2w.sv
module tb_regfile_write_2w;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clock;
  logic ctrl_reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  regfile_write_2w_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  regfile_write_2w #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  int checks;
  int failures;

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.ctrl_we0   = 1'b0; bus.ctrl_wreg0 = '0; bus.data_w0 = '0;
    bus.ctrl_we1   = 1'b0; bus.ctrl_wreg1 = '0; bus.data_w1 = '0;
    bus.ctrl_iss0  = 1'b0; bus.ctrl_ireg0 = '0;
    bus.ctrl_iss1  = 1'b0; bus.ctrl_ireg1 = '0;
  endtask

  task automatic wr0(input logic [ADDR_W-1:0] r, input logic [WIDTH-1:0] d);
    bus.ctrl_we0 = 1'b1; bus.ctrl_wreg0 = r; bus.data_w0 = d;
  endtask

  task automatic wr1(input logic [ADDR_W-1:0] r, input logic [WIDTH-1:0] d);
    bus.ctrl_we1 = 1'b1; bus.ctrl_wreg1 = r; bus.data_w1 = d;
  endtask

  task automatic iss0(input logic [ADDR_W-1:0] r);
    bus.ctrl_iss0 = 1'b1; bus.ctrl_ireg0 = r;
  endtask

  task automatic iss1(input logic [ADDR_W-1:0] r);
    bus.ctrl_iss1 = 1'b1; bus.ctrl_ireg1 = r;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] reg_of(input int i);
    return bus.regs_flat[WIDTH*i +: WIDTH];
  endfunction

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    checks++;
    assert (bus.regs_flat === '0) else begin
      failures++;
      $error("FAIL %s observed=nonzero regs_flat expected=all zero", tag);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    idle();

    // 1. Reset held two cycles with a write presented.
    ctrl_reset = 1'b0;
    wr0(5'd3, 32'hDEADBEEF);
    tick();
    tick();
    chk_all_zero("reset_regs");
    chk("reset_pending", bus.pending, 32'h0);
    chk("reset_conflict", {31'b0, bus.wr_conflict}, 32'h0);

    ctrl_reset = 1'b1;
    idle();
    tick();
    chk("post_reset_reg3", reg_of(3), 32'h0);

    // 2. Dual write to different registers.
    wr0(5'd5, 32'h11111111);
    wr1(5'd9, 32'h22222222);
    tick();
    idle();
    chk("dual_reg5", reg_of(5), 32'h11111111);
    chk("dual_reg9", reg_of(9), 32'h22222222);
    chk("dual_reg10", reg_of(10), 32'h0);
    chk("dual_conflict", {31'b0, bus.wr_conflict}, 32'h0);
    chk("dual_pending", bus.pending, 32'h0);

    // 3. Collision: slot 1 wins, one-cycle conflict pulse.
    wr0(5'd7, 32'hAAAA0000);
    wr1(5'd7, 32'h0000BBBB);
    tick();
    idle();
    chk("coll_reg7", reg_of(7), 32'h0000BBBB);
    chk("coll_conflict_hi", {31'b0, bus.wr_conflict}, 32'h1);
    tick();
    chk("coll_conflict_lo", {31'b0, bus.wr_conflict}, 32'h0);
    chk("coll_reg7_hold", reg_of(7), 32'h0000BBBB);

    // 4. Register 0: writes dropped, never pending, no conflict on r0.
    wr0(5'd0, 32'hFFFFFFFF);
    wr1(5'd0, 32'hFFFFFFFF);
    iss0(5'd0);
    tick();
    idle();
    chk("r0_value", reg_of(0), 32'h0);
    chk("r0_pending", bus.pending, 32'h0);
    chk("r0_conflict", {31'b0, bus.wr_conflict}, 32'h0);

    // 5. Scoreboard set / set-beats-clear / clear.
    iss0(5'd4);
    tick();
    idle();
    chk("sb_a_pending", bus.pending, 32'h0000_0010);
    wr1(5'd4, 32'h44440001);
    iss1(5'd4);
    tick();
    idle();
    chk("sb_b_pending", bus.pending, 32'h0000_0010);
    chk("sb_b_reg4", reg_of(4), 32'h44440001);
    wr0(5'd4, 32'h44440002);
    tick();
    idle();
    chk("sb_c_pending", bus.pending, 32'h0);
    chk("sb_c_reg4", reg_of(4), 32'h44440002);

    // Both issue slots on one register: a single writeback clears it.
    iss0(5'd20);
    iss1(5'd20);
    tick();
    idle();
    chk("sb_dup_set", bus.pending, 32'h0010_0000);
    wr0(5'd20, 32'h20202020);
    tick();
    idle();
    chk("sb_dup_clr", bus.pending, 32'h0);
    chk("sb_dup_reg20", reg_of(20), 32'h20202020);

    // 6. Reset mid-operation, including a colliding write in the reset cycle.
    iss0(5'd4);
    iss1(5'd12);
    wr0(5'd12, 32'h5);
    tick();
    idle();
    chk("mid_pending", bus.pending, 32'h0000_1010);
    chk("mid_reg12", reg_of(12), 32'h5);
    ctrl_reset = 1'b0;
    wr0(5'd12, 32'h7);
    wr1(5'd12, 32'h9);
    iss0(5'd13);
    tick();
    ctrl_reset = 1'b1;
    idle();
    chk("mid_rst_reg12", reg_of(12), 32'h0);
    chk("mid_rst_pending", bus.pending, 32'h0);
    chk("mid_rst_conflict", {31'b0, bus.wr_conflict}, 32'h0);
    chk_all_zero("mid_rst_regs");
    wr0(5'd12, 32'h9);
    tick();
    idle();
    chk("post_rst_reg12", reg_of(12), 32'h9);
    chk("post_rst_reg5", reg_of(5), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
